// File: rtl/fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch, in-order response buffering
// and redirect handling with stale-response discard.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [31:0] dec_pc_plus4
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_mem_q [DEPTH];
  logic [31:0]   pc_mem_q    [DEPTH];

  logic          req_fire, push, pop, not_empty;
  logic [SW-1:0] credits_used;
  logic [31:0]   target_pc;
  logic          unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc[1:0];
  assign target_pc = {redirect_pc[31:2], 2'b00};

  assign credits_used   = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = !rst && !redirect_valid && (credits_used < SW'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign not_empty    = (count_q != '0);
  assign dec_valid    = not_empty && !redirect_valid;
  assign dec_instr    = not_empty ? instr_mem_q[rd_ptr_q] : 32'h0;
  assign dec_pc       = not_empty ? pc_mem_q[rd_ptr_q] : 32'h0;
  assign dec_pc_plus4 = not_empty ? pc_mem_q[rd_ptr_q] + 32'd4 : 32'h0;

  // A response is buffered only when no stale responses remain ahead of it.
  assign push = imem_rsp_valid && (drop_q == '0) && !redirect_valid;
  assign pop  = dec_valid && dec_ready;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    count_d    = count_q;
    outst_d    = outst_q;
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    if (redirect_valid) begin
      fetch_pc_d = target_pc;
      rsp_pc_d   = target_pc;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      outst_d    = outst_q - CW'(imem_rsp_valid);
      // Everything still in flight after this cycle belongs to the old path.
      drop_d     = outst_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outst_d = outst_q + CW'(req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      count_q    <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      count_q    <= count_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      instr_mem_q[wr_ptr_q] <= imem_rsp_data;
      pc_mem_q[wr_ptr_q]    <= rsp_pc_q;
    end
  end

  no_overflow_a: assert property (@(posedge clk) disable iff (rst)
    !(push && (count_q == CW'(DEPTH))));

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised and directed bench for fetch_unit against a queue-based reference model
// of the memory, the instruction buffer and the expected fetch/decode streams.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        dec_valid;
  logic        dec_ready = 1'b0;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic [31:0] dec_pc_plus4;

  always #5 clk = ~clk;

  fetch_unit #(
    .RESET_PC(RST_PC),
    .DEPTH   (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .dec_valid     (dec_valid),
    .dec_ready     (dec_ready),
    .dec_instr     (dec_instr),
    .dec_pc        (dec_pc),
    .dec_pc_plus4  (dec_pc_plus4)
  );

  typedef struct {logic [31:0] addr; int unsigned due;} mreq_t;
  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;

  mreq_t       memq[$];
  ent_t        mfifo[$];
  logic [31:0] m_fetch, m_rsp_pc;
  int unsigned m_drop;
  bit          model_ok = 1'b0;
  int unsigned cyc = 0;
  int unsigned lat_min = 1, lat_max = 1;
  logic [31:0] data_xor = 32'h0;
  int          n_cmp = 0, n_err = 0;

  logic        s_req_valid, s_dec_valid, s_fire, s_pop;
  logic [31:0] s_req_addr, s_dec_instr, s_dec_pc, s_dec_p4;

  // One clock cycle: drive at negedge, sample and check, then advance the model at posedge.
  task automatic step(input logic r, input logic rd, input logic [31:0] rpc,
                      input logic rq, input logic dr);
    logic rsp, exp_rv, exp_dv;
    logic [31:0] rdata;
    mreq_t m;
    ent_t  e;
    rst = r; redirect_valid = rd; redirect_pc = rpc; imem_req_ready = rq; dec_ready = dr;
    rsp   = !r && (memq.size() > 0) && (memq[0].due <= cyc);
    rdata = rsp ? (memq[0].addr ^ data_xor) : $urandom;
    imem_rsp_valid = rsp;
    imem_rsp_data  = rdata;
    #1;
    s_req_valid = imem_req_valid; s_req_addr = imem_req_addr;
    s_dec_valid = dec_valid; s_dec_instr = dec_instr; s_dec_pc = dec_pc;
    s_dec_p4 = dec_pc_plus4;
    s_fire = s_req_valid && rq;
    s_pop  = s_dec_valid && dr;
    exp_rv = !r && !rd && ((mfifo.size() + memq.size()) < DEPTH);
    exp_dv = (mfifo.size() > 0) && !rd;
    if (model_ok) begin
      n_cmp++;
      if (s_req_valid !== exp_rv) begin
        n_err++;
        $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, s_req_valid, exp_rv);
      end
      if (!r) begin
        n_cmp++;
        if (s_req_addr !== m_fetch) begin
          n_err++;
          $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, s_req_addr, m_fetch);
        end
      end
      n_cmp++;
      if (s_dec_valid !== exp_dv) begin
        n_err++;
        $display("FAIL dec_valid cyc=%0d got=%b exp=%b", cyc, s_dec_valid, exp_dv);
      end
      if (mfifo.size() > 0) begin
        n_cmp++;
        if (s_dec_pc !== mfifo[0].pc || s_dec_instr !== mfifo[0].instr ||
            s_dec_p4 !== mfifo[0].pc + 32'd4) begin
          n_err++;
          $display("FAIL dec_head cyc=%0d got pc=%h instr=%h p4=%h exp pc=%h instr=%h",
                   cyc, s_dec_pc, s_dec_instr, s_dec_p4, mfifo[0].pc, mfifo[0].instr);
        end
      end else begin
        n_cmp++;
        if (s_dec_pc !== 32'h0 || s_dec_instr !== 32'h0 || s_dec_p4 !== 32'h0) begin
          n_err++;
          $display("FAIL dec_empty cyc=%0d got pc=%h instr=%h p4=%h exp 0",
                   cyc, s_dec_pc, s_dec_instr, s_dec_p4);
        end
      end
    end
    @(posedge clk);
    if (r) begin
      memq.delete(); mfifo.delete();
      m_fetch = RST_PC; m_rsp_pc = RST_PC; m_drop = 0; model_ok = 1'b1;
    end else if (model_ok) begin
      if (rsp) void'(memq.pop_front());
      if (rd) begin
        mfifo.delete();
        m_drop   = memq.size();
        m_fetch  = {rpc[31:2], 2'b00};
        m_rsp_pc = {rpc[31:2], 2'b00};
      end else begin
        if (exp_rv && rq) begin
          m.addr = m_fetch;
          m.due  = cyc + $urandom_range(lat_max, lat_min);
          memq.push_back(m);
          m_fetch = m_fetch + 32'd4;
        end
        if (exp_dv && dr) void'(mfifo.pop_front());
        if (rsp) begin
          if (m_drop > 0) m_drop--;
          else begin
            e.pc = m_rsp_pc; e.instr = rdata;
            mfifo.push_back(e);
            m_rsp_pc = m_rsp_pc + 32'd4;
          end
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    n_cmp++;
    if (s_dec_valid !== 1'b0 || s_req_valid !== 1'b1 || s_req_addr !== RST_PC) begin
      n_err++;
      $display("FAIL reset_state got dv=%b rv=%b addr=%h exp dv=0 rv=1 addr=%h",
               s_dec_valid, s_req_valid, s_req_addr, RST_PC);
    end
  endtask

  task automatic test_stream();
    int first_k = -1;
    int npop = 0;
    data_xor = 32'h0; lat_min = 1; lat_max = 1;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (s_pop) begin
        if (first_k < 0) first_k = k;
        n_cmp++;
        if (s_dec_pc !== RST_PC + 32'(4 * npop) || s_dec_instr !== s_dec_pc ||
            s_dec_p4 !== s_dec_pc + 32'd4) begin
          n_err++;
          $display("FAIL stream_order got pc=%h instr=%h p4=%h exp pc=%h",
                   s_dec_pc, s_dec_instr, s_dec_p4, RST_PC + 32'(4 * npop));
        end
        npop++;
      end
    end
    n_cmp++;
    if (first_k != 2 || npop < 8) begin
      n_err++;
      $display("FAIL stream_fill got first=%0d pops=%0d exp first=2 pops>=8", first_k, npop);
    end
  endtask

  task automatic test_backpressure();
    int fires = 0;
    int npop = 0;
    data_xor = 32'hA5A5_0F0F; lat_min = 1; lat_max = 1;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      if (s_fire) fires++;
    end
    n_cmp++;
    if (fires != 2 || s_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bp_credits got fires=%0d rv=%b exp fires=2 rv=0", fires, s_req_valid);
    end
    for (int k = 0; k < 10 && npop < 2; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (s_pop) begin
        n_cmp++;
        if (s_dec_pc !== RST_PC + 32'(4 * npop)) begin
          n_err++;
          $display("FAIL bp_release got pc=%h exp=%h", s_dec_pc, RST_PC + 32'(4 * npop));
        end
        npop++;
      end
    end
    n_cmp++;
    if (npop != 2) begin
      n_err++;
      $display("FAIL bp_release_count got=%0d exp=2", npop);
    end
  endtask

  task automatic test_redirect();
    bit seen = 1'b0;
    data_xor = 32'h1357_9BDF; lat_min = 3; lat_max = 3;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h10, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++;
    if (!s_fire || s_req_addr !== 32'h10) begin
      n_err++;
      $display("FAIL redir_req0 got fire=%b addr=%h exp fire=1 addr=10", s_fire, s_req_addr);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++;
    if (!s_fire || s_req_addr !== 32'h14) begin
      n_err++;
      $display("FAIL redir_req1 got fire=%b addr=%h exp fire=1 addr=14", s_fire, s_req_addr);
    end
    step(1'b0, 1'b1, 32'h100, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++;
    if (s_req_addr !== 32'h100) begin
      n_err++;
      $display("FAIL redir_addr got=%h exp=00000100", s_req_addr);
    end
    for (int k = 0; k < 20 && !seen; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (s_pop) begin
        seen = 1'b1;
        n_cmp++;
        if (s_dec_pc !== 32'h100 || s_dec_instr !== (32'h100 ^ 32'h1357_9BDF)) begin
          n_err++;
          $display("FAIL redir_first got pc=%h instr=%h exp pc=00000100", s_dec_pc, s_dec_instr);
        end
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL redir_timeout got no pop exp pop within 20 cycles");
    end
  endtask

  task automatic test_wrap();
    bit seen = 1'b0;
    data_xor = 32'h0BAD_F00D; lat_min = 1; lat_max = 1;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 32'h203, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++;
    if (s_req_addr !== 32'h200 || !s_req_valid) begin
      n_err++;
      $display("FAIL align_addr got=%h v=%b exp=00000200 v=1", s_req_addr, s_req_valid);
    end
    for (int k = 0; k < 10 && !seen; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (s_pop) begin
        seen = 1'b1;
        n_cmp++;
        if (s_dec_pc !== 32'h200) begin
          n_err++;
          $display("FAIL align_dec got=%h exp=00000200", s_dec_pc);
        end
      end
    end
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++;
    if (s_req_addr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_addr got=%h exp=00000000", s_req_addr);
    end
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      if (s_pop) begin
        seen = 1'b1;
        n_cmp++;
        if (s_dec_pc !== 32'hFFFF_FFFC || s_dec_p4 !== 32'h0) begin
          n_err++;
          $display("FAIL wrap_plus4 got pc=%h p4=%h exp pc=fffffffc p4=0", s_dec_pc, s_dec_p4);
        end
      end
    end
    n_cmp++;
    if (!seen) begin
      n_err++;
      $display("FAIL wrap_timeout got no pop exp pop within 10 cycles");
    end
  endtask

  task automatic test_req_stall();
    lat_min = 1; lat_max = 2;
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
      n_cmp++;
      if (!s_req_valid || s_req_addr !== RST_PC) begin
        n_err++;
        $display("FAIL stall_hold got v=%b addr=%h exp v=1 addr=%h",
                 s_req_valid, s_req_addr, RST_PC);
      end
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    n_cmp++;
    if (s_req_addr !== RST_PC + 32'd4) begin
      n_err++;
      $display("FAIL stall_advance got=%h exp=%h", s_req_addr, RST_PC + 32'd4);
    end
  endtask

  task automatic test_mid_reset();
    lat_min = 1; lat_max = 1; data_xor = 32'h7777_0000;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 10 && mfifo.size() < 2; k++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    redirect_pc = 32'h0;
    step(1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
    for (int k = 0; k < 10 && mfifo.size() < 2; k++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (s_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mrst_full got rv=%b exp=0", s_req_valid);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    n_cmp++;
    if (s_req_valid !== 1'b0) begin
      n_err++;
      $display("FAIL mrst_rv_in_rst got=%b exp=0", s_req_valid);
    end
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    n_cmp++;
    if (s_dec_valid !== 1'b0 || s_req_addr !== RST_PC || s_req_valid !== 1'b1) begin
      n_err++;
      $display("FAIL mrst_after got dv=%b addr=%h rv=%b exp dv=0 addr=%h rv=1",
               s_dec_valid, s_req_addr, s_req_valid, RST_PC);
    end
  endtask

  task automatic test_random();
    logic r, rd;
    lat_min = 1; lat_max = 4;
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
    for (int k = 0; k < 3000; k++) begin
      if (k % 500 == 0) data_xor = $urandom;
      r  = ($urandom_range(199, 0) == 0);
      rd = !r && ($urandom_range(19, 0) == 0);
      step(r, rd, $urandom, 1'($urandom_range(3, 0) != 0), 1'($urandom_range(3, 0) != 0));
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_req_stall();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
